// File: rtl/line_buffer_pkg.sv
// Shared pixel-stream constants for the line buffer and its delay lines.
package line_buffer_pkg;

    localparam int unsigned PIX_NUM_BITS   = 8;
    localparam int unsigned PIX_LINE_WIDTH = 320;
    localparam int unsigned PIX_NUM_LINES  = 3;

endpackage : line_buffer_pkg

// File: rtl/line_buffer_line.sv
// One line of pixel delay: a DEPTH-deep shift register that advances only on shift.
// Storage is deliberately unreset so it can map onto RAM or SRL primitives.
module line_delay
    import line_buffer_pkg::*;
#(
    parameter int unsigned NUM_BITS = PIX_NUM_BITS,
    parameter int unsigned DEPTH    = PIX_LINE_WIDTH
) (
    input  logic                clk,
    input  logic                shift,
    input  logic [NUM_BITS-1:0] d,
    output logic [NUM_BITS-1:0] q
);

    logic [NUM_BITS-1:0] mem_q [DEPTH];

    // Shift the whole line by one pixel per accepted strobe
    always_ff @(posedge clk) begin
        if (shift) begin
            mem_q[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) begin
                mem_q[i] <= mem_q[i-1];
            end
        end
    end

    assign q = mem_q[DEPTH-1];

endmodule : line_delay

// File: rtl/line_buffer.sv
// Sliding window column generator: chains NUM_LINES-1 line delays so that
// taps presents the same column from the current and previous lines, with
// column/row position tracking, end-of-line and window-valid pulses.
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter int unsigned NUM_BITS   = PIX_NUM_BITS,
    parameter int unsigned LINE_WIDTH = PIX_LINE_WIDTH,
    parameter int unsigned NUM_LINES  = PIX_NUM_LINES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              shift,
    input  logic                              sof,
    input  logic [NUM_BITS-1:0]               sr_in,
    output logic [NUM_LINES*NUM_BITS-1:0]     taps,
    output logic                              taps_valid,
    output logic                              eol,
    output logic [$clog2(LINE_WIDTH)-1:0]     col,
    output logic [$clog2(NUM_LINES)-1:0]      row
);

    localparam int unsigned COL_W  = $clog2(LINE_WIDTH);
    localparam int unsigned ROW_W  = $clog2(NUM_LINES);
    localparam int unsigned TAPS_W = NUM_LINES * NUM_BITS;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_LINES - 1);

    logic [COL_W-1:0]    col_cnt_q, col_cnt_d;
    logic [ROW_W-1:0]    row_cnt_q, row_cnt_d;
    logic [TAPS_W-1:0]   taps_q, taps_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                valid_q, valid_d;
    logic                eol_q, eol_d;

    logic [COL_W-1:0]    pix_col_c;
    logic [ROW_W-1:0]    pix_row_c;
    logic                line_shift_c;
    logic [NUM_BITS-1:0] tap_col_c [NUM_LINES];

    // A pixel arriving together with reset is dropped, so the lines must not move
    assign line_shift_c = shift & ~reset;
    assign tap_col_c[0] = sr_in;

    // Delay line k-1 output feeds delay line k; its output is tap slice k
    for (genvar k = 1; k < int'(NUM_LINES); k++) begin : g_line
        line_delay #(
            .NUM_BITS (NUM_BITS),
            .DEPTH    (LINE_WIDTH)
        ) u_line_delay (
            .clk   (clk),
            .shift (line_shift_c),
            .d     (tap_col_c[k-1]),
            .q     (tap_col_c[k])
        );
    end

    // Position of the accepted pixel, counter advance and registered output values
    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        taps_d    = taps_q;
        col_d     = col_q;
        row_d     = row_q;
        valid_d   = 1'b0;
        eol_d     = 1'b0;
        pix_col_c = sof ? '0 : col_cnt_q;
        pix_row_c = sof ? '0 : row_cnt_q;

        if (shift) begin
            for (int k = 0; k < int'(NUM_LINES); k++) begin
                taps_d[k*NUM_BITS +: NUM_BITS] = tap_col_c[k];
            end
            col_d   = pix_col_c;
            row_d   = pix_row_c;
            eol_d   = (pix_col_c == COL_LAST);
            valid_d = (pix_row_c == ROW_LAST);

            col_cnt_d = eol_d ? '0 : pix_col_c + COL_W'(1);
            row_cnt_d = (eol_d && !valid_d) ? pix_row_c + ROW_W'(1) : pix_row_c;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            taps_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            taps_q    <= taps_d;
            col_q     <= col_d;
            row_q     <= row_d;
            valid_q   <= valid_d;
            eol_q     <= eol_d;
        end
    end

    assign taps       = taps_q;
    assign taps_valid = valid_q;
    assign eol        = eol_q;
    assign col        = col_q;
    assign row        = row_q;

endmodule : line_buffer

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, pixel width in bits.
REQ-002 SHALL have parameter LINE_WIDTH, default 320, pixels per line, legal range >= 2.
REQ-003 SHALL have parameter NUM_LINES, default 3, vertical taps in the window column, legal range >= 2.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port shift, input, 1, pixel-valid strobe; sr_in accepted on any edge where shift=1.
REQ-007 SHALL have port sof, input, 1, start-of-frame marker, qualified by shift.
REQ-008 SHALL have port sr_in, input, NUM_BITS, incoming pixel.
REQ-009 SHALL have port taps, output, NUM_LINES*NUM_BITS, window column; slice k = pixel from k lines above, same column.
REQ-010 SHALL have port taps_valid, output, 1, one-cycle pulse; taps holds a fully populated column.
REQ-011 SHALL have port eol, output, 1, one-cycle pulse; last pixel of a line was accepted.
REQ-012 SHALL have port col, output, clog2(LINE_WIDTH), column index of the pixel in taps.
REQ-013 SHALL have port row, output, clog2(NUM_LINES), saturating row count of the pixel in taps.

Function
REQ-014 SHALL treat each accepted pixel as being at (row_cnt, col_cnt), then advance col_cnt by 1.
REQ-015 SHALL wrap col_cnt from LINE_WIDTH-1 to 0 and increment row_cnt on that wrap, saturating at NUM_LINES-1.
REQ-016 SHALL store each accepted pixel in delay line 0; delay line k-1 output feeds delay line k, each LINE_WIDTH deep, all advancing only on shift.
REQ-017 SHALL register outputs with latency 1: after edge N accepts a pixel, taps, col, row, eol and taps_valid reflect that pixel from edge N+1.
REQ-018 SHALL drive taps slice 0 with the accepted sr_in and slice k with the pixel accepted k*LINE_WIDTH shifts earlier.
REQ-019 SHALL assert taps_valid only when the accepted pixel has row_cnt = NUM_LINES-1.
REQ-020 SHALL assert eol only when the accepted pixel has col_cnt = LINE_WIDTH-1.
REQ-021 SHALL, on cycles without shift, deassert taps_valid and eol, hold taps/col/row, and leave delay lines and counters unchanged.
REQ-022 SHALL, on shift=1 with sof=1, treat the pixel as (0,0) and continue counting from there; fill state restarts.
REQ-023 SHALL ignore sof when shift=0.
REQ-024 SHALL treat stale delay-line contents after sof or reset as don't-care, masked by taps_valid.

Reset
REQ-025 SHALL, on reset=1 at an edge, clear col_cnt, row_cnt, taps, col, row, taps_valid and eol to 0.
REQ-026 SHALL give reset priority over shift and sof in the same cycle; that pixel is dropped.
REQ-027 SHALL leave delay-line storage unreset so it can map to RAM/shift primitives.

Structure
REQ-028 SHALL take shared pixel-stream constants (default NUM_BITS, LINE_WIDTH) from the team's shared pixel definitions include.
REQ-029 SHALL implement each delay line as sub-module line_delay (params NUM_BITS, DEPTH; ports clk, shift, d, q), instantiated NUM_LINES-1 times via generate.

Verification (NUM_BITS=8, LINE_WIDTH=4, NUM_LINES=3, pixel value = row*16+col)
REQ-030 SHALL cover reset: hold reset 2 cycles -> taps=0, col=0, row=0, taps_valid=0, eol=0.
REQ-031 SHALL cover frame fill: 12 back-to-back pixels with sof on the first -> taps_valid low for pixels 0..7; pixel 8 yields taps slices {0x20,0x10,0x00}, taps_valid=1, col=0, row=2.
REQ-032 SHALL cover stalls: same frame with 0-3 idle cycles randomly inserted -> identical taps sequence; outputs held and pulses low on idle cycles.
REQ-033 SHALL cover line wrap: eol pulses after pixels 3, 7 and 11 only; col returns to 0 on the next pixel.
REQ-034 SHALL cover sof mid-frame: sof at pixel 6 -> col=0, row=0 for that pixel; taps_valid low for the next 8 pixels, high on the 9th.
REQ-035 SHALL cover reset mid-frame: reset during pixel 9 with shift=1 -> pixel dropped, outputs 0, next pixel reported as col=0, row=0.
